// File: rtl/mac_seq_ctrl_if.sv
// Control bus between the core controller / L0 side and the MAC-array sequencer.
// The master side drives job requests and the L0 status; the slave side is the sequencer.
interface mac_seq_ctrl_if #(
  parameter int len_bw = 8
);
  logic              start;
  logic              is_os_in;
  logic              act_4b_mode_in;
  logic [len_bw-1:0] num_vec;
  logic              l0_empty;
  logic              l0_rd;
  logic [2:0]        inst_w;
  logic              is_os;
  logic              act_4b_mode;
  logic              busy;
  logic              done;

  modport master (
    output start, is_os_in, act_4b_mode_in, num_vec, l0_empty,
    input  l0_rd, inst_w, is_os, act_4b_mode, busy, done
  );

  modport slave (
    input  start, is_os_in, act_4b_mode_in, num_vec, l0_empty,
    output l0_rd, inst_w, is_os, act_4b_mode, busy, done
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// MAC-array sequencer: walks a WS or OS job through its phases, issuing L0 reads and
// the matching 3-bit instruction one cycle later to the array's west edge.
module mac_seq_ctrl #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int len_bw = 8
) (
  input  logic           clk,
  input  logic           reset,
  mac_seq_ctrl_if.slave  bus
);
  localparam int vec_max = (1 << len_bw) - 1;
  localparam int max_a   = (col > vec_max) ? col : vec_max;
  localparam int cnt_max = (max_a > row + col) ? max_a : row + col;
  localparam int cnt_w   = $clog2(cnt_max + 1);

  localparam logic [cnt_w-1:0] cnt_one    = cnt_w'(1);
  localparam logic [cnt_w-1:0] load_last  = cnt_w'(col - 1);
  localparam logic [cnt_w-1:0] wait_last  = cnt_w'(row + col - 2);
  localparam logic [cnt_w-1:0] flush_last = cnt_w'(row - 1);
  localparam logic [cnt_w-1:0] drain_last = cnt_w'(row + col - 1);

  localparam logic [2:0] inst_load  = 3'b001;
  localparam logic [2:0] inst_exec  = 3'b010;
  localparam logic [2:0] inst_flush = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_GAP, ST_EXEC, ST_WAIT, ST_FLUSH, ST_DRAIN, ST_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [cnt_w-1:0]  cnt_reg, cnt_next;
  logic [len_bw-1:0] num_vec_reg;
  logic              is_os_reg, act_4b_reg;
  logic              l0_rd_reg, l0_rd_next;
  logic [2:0]        pend_reg, pend_next;
  logic [2:0]        inst_w_reg;
  logic              busy_reg, done_reg;
  logic [cnt_w-1:0]  exec_last;
  logic              accept;

  assign exec_last = cnt_w'(num_vec_reg) - cnt_one;
  assign accept    = (state_reg == ST_IDLE) && bus.start;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    l0_rd_next = 1'b0;
    pend_next  = 3'b000;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          cnt_next = '0;
          if (bus.is_os_in)
            state_next = (bus.num_vec == '0) ? ST_WAIT : ST_EXEC;
          else
            state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // an empty L0 freezes the issue slot; the counter only advances on real reads
        if (!bus.l0_empty) begin
          l0_rd_next = 1'b1;
          pend_next  = inst_load;
          if (cnt_reg == load_last) begin
            state_next = ST_GAP;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + cnt_one;
          end
        end
      end
      ST_GAP: begin
        state_next = (num_vec_reg == '0) ? ST_DRAIN : ST_EXEC;
      end
      ST_EXEC: begin
        if (!bus.l0_empty) begin
          l0_rd_next = 1'b1;
          pend_next  = inst_exec;
          if (cnt_reg == exec_last) begin
            state_next = is_os_reg ? ST_WAIT : ST_DRAIN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + cnt_one;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg == wait_last) begin
          state_next = ST_FLUSH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + cnt_one;
        end
      end
      ST_FLUSH: begin
        pend_next = inst_flush;
        if (cnt_reg == flush_last) begin
          state_next = ST_DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + cnt_one;
        end
      end
      ST_DRAIN: begin
        if (cnt_reg == drain_last) begin
          state_next = ST_DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + cnt_one;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      num_vec_reg <= '0;
      is_os_reg   <= 1'b0;
      act_4b_reg  <= 1'b0;
      l0_rd_reg   <= 1'b0;
      pend_reg    <= 3'b000;
      inst_w_reg  <= 3'b000;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      l0_rd_reg  <= l0_rd_next;
      // pend_reg tracks the read issued this cycle; it reaches inst_w one cycle after l0_rd
      pend_reg   <= pend_next;
      inst_w_reg <= pend_reg;
      busy_reg   <= (state_next != ST_IDLE);
      done_reg   <= (state_next == ST_DONE);
      if (accept) begin
        num_vec_reg <= bus.num_vec;
        is_os_reg   <= bus.is_os_in;
        act_4b_reg  <= bus.act_4b_mode_in;
      end
    end
  end

  assign bus.l0_rd       = l0_rd_reg;
  assign bus.inst_w      = inst_w_reg;
  assign bus.is_os       = is_os_reg;
  assign bus.act_4b_mode = act_4b_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: a slot-queue model of each job predicts every output per cycle,
// and per-job tallies are pinned against hand-computed totals.
module tb_mac_seq_ctrl;
  localparam int row    = 8;
  localparam int col    = 8;
  localparam int len_bw = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.len_bw(len_bw)) bus ();

  mac_seq_ctrl #(.row(row), .col(col), .len_bw(len_bw)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One slot per busy cycle; 'need' slots consume one L0 word and wait while L0 is empty.
  typedef struct packed {
    logic       need;
    logic [2:0] code;
    logic       fin;
  } tok_t;

  tok_t       model_q[$];
  logic       rd_d1 = 1'b0;
  logic [2:0] code_d1 = 3'b000;
  logic [2:0] code_d2 = 3'b000;
  logic       exp_os = 1'b0;
  logic       exp_a4 = 1'b0;

  int t_busy, t_done, t_rd, t_n1, t_n2, t_n4;

  function automatic void push_n(input int n, input logic need, input logic [2:0] code);
    for (int i = 0; i < n; i++) model_q.push_back('{need: need, code: code, fin: 1'b0});
  endfunction

  function automatic void push_job(input logic os, input int nv);
    if (os) begin
      push_n(nv, 1'b1, 3'b010);
      push_n(row + col - 1, 1'b0, 3'b000);
      push_n(row, 1'b0, 3'b100);
    end else begin
      push_n(col, 1'b1, 3'b001);
      push_n(1, 1'b0, 3'b000);
      push_n(nv, 1'b1, 3'b010);
    end
    push_n(row + col, 1'b0, 3'b000);
    model_q.push_back('{need: 1'b0, code: 3'b000, fin: 1'b1});
  endfunction

  always @(negedge clk) begin
    logic       rd_now;
    logic [2:0] code_now;
    if (!reset) begin
      model_q.delete();
      rd_d1 = 1'b0; code_d1 = 3'b000; code_d2 = 3'b000;
      exp_os = 1'b0; exp_a4 = 1'b0;
      chk("rst_busy", bus.busy, 0);
      chk("rst_l0_rd", bus.l0_rd, 0);
      chk("rst_inst_w", bus.inst_w, 0);
      chk("rst_done", bus.done, 0);
    end else begin
      chk("busy", bus.busy, model_q.size() != 0);
      chk("done", bus.done, (model_q.size() != 0) && model_q[0].fin);
      chk("l0_rd", bus.l0_rd, rd_d1);
      chk("inst_w", bus.inst_w, code_d2);
      chk("is_os", bus.is_os, exp_os);
      chk("act_4b_mode", bus.act_4b_mode, exp_a4);
      chk("inst_onehot", $countones(bus.inst_w) <= 1, 1);
      t_busy += bus.busy; t_done += bus.done; t_rd += bus.l0_rd;
      t_n1 += (bus.inst_w == 3'b001); t_n2 += (bus.inst_w == 3'b010);
      t_n4 += (bus.inst_w == 3'b100);
      rd_now = 1'b0;
      code_now = 3'b000;
      if (model_q.size() == 0) begin
        if (bus.start) begin
          push_job(bus.is_os_in, int'(bus.num_vec));
          exp_os = bus.is_os_in;
          exp_a4 = bus.act_4b_mode_in;
        end
      end else if (!(model_q[0].need && bus.l0_empty)) begin
        rd_now = model_q[0].need;
        code_now = model_q[0].code;
        void'(model_q.pop_front());
      end
      code_d2 = code_d1;
      code_d1 = code_now;
      rd_d1 = rd_now;
    end
  end

  task automatic clear_tally();
    t_busy = 0; t_done = 0; t_rd = 0; t_n1 = 0; t_n2 = 0; t_n4 = 0;
  endtask

  task automatic run_job(input string nm, input bit os, input bit a4, input int nv,
                         input int st_at, input int st_len, input int rep_at,
                         input int e_busy, input int e_n1, input int e_n2, input int e_n4);
    bit ended = 1'b0;
    @(posedge clk); #1;
    clear_tally();
    bus.start = 1'b1; bus.is_os_in = os; bus.act_4b_mode_in = a4;
    bus.num_vec = len_bw'(nv); bus.l0_empty = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      @(posedge clk); #1;
      if (rep_at > 0 && (c == rep_at || c == e_busy)) begin
        bus.start = 1'b1; bus.is_os_in = ~os; bus.act_4b_mode_in = ~a4;
        bus.num_vec = len_bw'(nv + 3);
      end else begin
        bus.start = 1'b0;
      end
      bus.l0_empty = (c >= st_at) && (c < st_at + st_len);
      if (c > 1 && !bus.busy) begin
        ended = 1'b1;
        break;
      end
    end
    bus.start = 1'b0; bus.l0_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_ended"}, ended, 1);
    chk({nm, "_busy_cycles"}, t_busy, e_busy);
    chk({nm, "_done_pulses"}, t_done, 1);
    chk({nm, "_n001"}, t_n1, e_n1);
    chk({nm, "_n010"}, t_n2, e_n2);
    chk({nm, "_n100"}, t_n4, e_n4);
    chk({nm, "_rd_count"}, t_rd, e_n1 + e_n2);
    $display("job %s: busy=%0d done=%0d rd=%0d n001=%0d n010=%0d n100=%0d",
             nm, t_busy, t_done, t_rd, t_n1, t_n2, t_n4);
  endtask

  initial begin
    bus.start = 1'b0; bus.is_os_in = 1'b0; bus.act_4b_mode_in = 1'b0;
    bus.num_vec = '0; bus.l0_empty = 1'b0;
    #3;
    chk("init_busy", bus.busy, 0);
    chk("init_inst_w", bus.inst_w, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    //      name        os a4 nv  st_at len rep busy n001 n010 n100
    run_job("ws16",      0, 0, 16, 0,    0,  0,  42,  8,   16,  0);
    run_job("os4",       1, 1, 4,  0,    0,  0,  44,  0,   4,   8);
    run_job("ws16_stall",0, 1, 16, 15,   3,  0,  45,  8,   16,  0);
    run_job("ws0",       0, 0, 0,  0,    0,  0,  26,  8,   0,   0);
    run_job("os0",       1, 0, 0,  0,    0,  0,  40,  0,   0,   8);
    run_job("ws4_rep",   0, 0, 4,  5,    0,  5,  30,  8,   4,   0);
    run_job("os6_stall", 1, 1, 6,  2,    2,  0,  48,  0,   6,   8);
    run_job("ws2_lstall",0, 0, 2,  3,    1,  0,  29,  8,   2,   0);

    // abort an OS job mid-EXEC with an asynchronous reset
    @(posedge clk); #1;
    clear_tally();
    bus.start = 1'b1; bus.is_os_in = 1'b1; bus.act_4b_mode_in = 1'b1; bus.num_vec = 8'd16;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("abort_pre_busy", bus.busy, 1);
    chk("abort_pre_is_os", bus.is_os, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_l0_rd", bus.l0_rd, 0);
    chk("abort_inst_w", bus.inst_w, 0);
    chk("abort_is_os", bus.is_os, 0);
    chk("abort_act_4b", bus.act_4b_mode, 0);
    chk("abort_done", bus.done, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_done", t_done, 0);
    $display("job abort: reset mid-EXEC, done=%0d", t_done);

    run_job("os4_after", 1, 0, 4,  0,    0,  0,  44,  0,   4,   8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer for the MAC array: drives the single 3-bit instruction bus into the array's west edge; the array skews it across rows and columns.
- Weight-stationary (WS) encoding: inst = {reserved, execute, kernel load}.
- Output-stationary (OS) encoding: inst = {flush psum, execute, psum load}.
- Issues L0 read enables aligned with the instructions, stalls on L0 empty, and latches mode configuration for the whole job.
- Reports busy/done to the top-level core controller.

Parameters:
- row, 8, number of mac_row instances in the array
- col, 8, number of mac_tile per row
- len_bw, 8, width of the vector-count field

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  job start request; sampled only in IDLE
- is_os_in  input  1  mode for the job (1 = OS, 0 = WS)
- act_4b_mode_in  input  1  activation-precision mode for the job
- num_vec  input  len_bw  number of activation vectors to execute; sampled with start
- l0_empty  input  1  L0 FIFO empty flag
- l0_rd  output  1  L0 read enable
- inst_w  output  3  instruction to array row inputs
- is_os  output  1  latched mode, to array
- act_4b_mode  output  1  latched precision mode, to array
- busy  output  1  high from the start-accept edge through the DONE state
- done  output  1  one-cycle pulse in the DONE state

Behaviour:
- Reset (reset = 0, async): state = IDLE; all outputs 0; counters and latched config cleared. Reset asserted mid-job aborts immediately; no done pulse.
- All outputs registered.
- inst_w lags l0_rd by exactly one cycle: the instruction for the data read in cycle t is presented in cycle t+1, matching L0 read latency.
- Start accept: in IDLE with start = 1 at an edge, latch is_os_in, act_4b_mode_in and num_vec; busy = 1 from that edge.
  - start while busy is ignored.
  - is_os and act_4b_mode stay constant until the next accept.
- WS sequence: LOAD → GAP → EXEC → DRAIN → DONE → IDLE.
  - LOAD: col issue-cycles; l0_rd = 1; delayed inst = 3'b001.
  - GAP: 1 cycle; inst = 000.
  - EXEC: num_vec issue-cycles; l0_rd = 1; delayed inst = 3'b010.
  - DRAIN: row+col cycles; inst = 000, l0_rd = 0.
  - DONE: 1 cycle; done = 1, busy = 1.
- OS sequence: EXEC → WAIT → FLUSH → DRAIN → DONE → IDLE.
  - EXEC: num_vec issue-cycles; inst = 3'b010 (delayed).
  - WAIT: row+col-1 cycles; inst = 000.
  - FLUSH: row cycles; inst = 3'b100; l0_rd = 0.
  - DRAIN: row+col cycles.
  - DONE: as WS.
- Stall (LOAD and EXEC only): when l0_empty = 1, l0_rd = 0, the issue counter holds, and the next-cycle inst_w = 000. Resume when l0_empty = 0. No other state stalls.
- num_vec = 0: EXEC is skipped.
  - WS: GAP → DRAIN.
  - OS: directly to WAIT.
- Counters: saturating-free, width sufficient for max(col, 2^len_bw - 1, row+col). Counters compare against the terminal count, then reset to 0 on state change.
- inst_w never carries more than one set bit. The bit-2 flush and bit-0 load patterns never appear in the opposite mode's phases.
- Last delayed instruction: the EXEC→DRAIN (or →WAIT) transition still emits it; the pipeline register is not cleared at state change.

Test Plan:
- WS, row = col = 8, num_vec = 16, l0_empty = 0:
  - 8 cycles of inst 001, then 1 cycle of 000, then 16 cycles of 010; each inst lags l0_rd by 1 cycle.
  - done pulses once; busy high for 42 cycles.
- OS, num_vec = 4, no stall:
  - 4 cycles of 010, then 15 cycles of 000, then 8 cycles of 100, then DRAIN of 16 cycles.
  - busy = 44 cycles; is_os = 1 throughout.
- WS EXEC with l0_empty held high for 3 cycles mid-stream, num_vec = 16:
  - l0_rd is low for those 3 cycles; inst_w shows 3 gaps of 000.
  - Exactly 16 cycles of 010 in total; busy is extended by 3.
- num_vec = 0 in both modes:
  - WS emits no 010; busy = 8+1+16+1 = 26.
  - OS proceeds straight to WAIT; busy = 40.
- start re-pulsed during busy with is_os_in toggled: ignored; is_os unchanged; exactly one done pulse.
- reset driven low mid-EXEC: all outputs 0 asynchronously, before the next clk edge; after release, IDLE; a new start runs a full job correctly.
